jtag_tap_driver: RTL and testbench
==================================

# jtag_tap_driver

- Synthesizable JTAG master that generates TCK/TMS/TDI sequences for the slow-control TAP (`Sl_Ctrl`) and captures its TDO.
- Sits directly upstream of `Sl_Ctrl`, replacing hand-written TMS/TDI waveforms.
- One Start pulse performs an optional Test-Logic-Reset, a 6-bit IR write, then an optional DR shift of 1..DR_MAX bits.
- Returns the TAP to Run-Test/Idle and reports captured TDO bits.

## Interface
- IR_WIDTH, 6: instruction length (matches the `Sl_Ctrl` OpCode width).
- DR_MAX, 64: maximum DR shift length.
- DIV, 4: Clk cycles per TCK half-period (≥1).

- Clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle request; ignored while Busy.
- Tap_Rst  in  1  sampled with Start; 1 = prepend Test-Logic-Reset sequence.
- Instr  in  IR_WIDTH  opcode; sampled with Start.
- Dr_Len  in  7  DR bits to shift; 0 = IR only; values >DR_MAX clamp to DR_MAX; sampled with Start.
- Dr_In  in  DR_MAX  DR data, bit 0 shifted first; sampled with Start.
- Dr_Out  out  DR_MAX  captured TDO; bit k = k-th shifted bit; bits ≥Dr_Len are 0.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle completion pulse.
- TCK  out  1  JTAG clock; idles low.
- TMS  out  1  JTAG mode select.
- TDI  out  1  JTAG data to TAP.
- TDO  in  1  JTAG data from TAP.

## Operation
- FSM states: IDLE, TLR, IR_HDR, SHIFT_IR, IR_TRL, DR_HDR, SHIFT_DR, DR_TRL, FINISH.
- Each state step is one TCK period. The TMS value per period is listed below.
- TLR, entered when Tap_Rst=1 or a reset-pending flag is set: TMS 1,1,1,1,1,0 (6 periods). Clears the flag.
- IR_HDR: TMS 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
- SHIFT_IR: IR_WIDTH periods; TDI = Instr bit i, LSB first. TMS=0, except 1 on the last bit.
- IR_TRL: TMS 1,0 (Update-IR, Run-Test/Idle).
- If effective Dr_Len=0, go to FINISH.
- DR_HDR: TMS 1,0,0 (Select-DR, Capture-DR, Shift-DR).
- SHIFT_DR: N periods, N = effective Dr_Len. TDI = Dr_In bit k. TMS=1 on the last bit only. TDO sampled into Dr_Out[k].
- DR_TRL: TMS 1,0 (Update-DR, Run-Test/Idle).
- FINISH: Done pulse, return to IDLE.
- TDI=0 outside shift periods.
- Dr_Out is cleared when Start is accepted. Sampled bits are written as they arrive and held after Done.
- Total TCK periods: T = 6·Tap_Rst_eff + IR_WIDTH + 6 + (N>0 ? N+5 : 0).
- Rst mid-operation: all outputs take reset values immediately, the FSM goes to IDLE, and reset-pending is set. No Done is issued.
- Reset-pending also sets on power-up Rst, so the first operation always runs TLR.

## Timing
- Reset values: TCK=0, TMS=1, TDI=0, Busy=0, Done=0, Dr_Out=0, FSM=IDLE, reset-pending=1.
- Start is accepted at Clk edge 0. Busy rises at edge 1. The first TCK low phase begins at edge 1.
- TCK is low for DIV Clk cycles, then high for DIV cycles.
- TMS/TDI update on the same Clk edge that drives TCK low; they are stable through the rising edge.
- TDO is sampled on the Clk edge that drives TCK high.
- After the last high phase, TCK returns low and Busy drops. Done pulses on that same edge: edge 1 + 2·DIV·T.
- Start in the Done cycle is accepted; a new Busy begins on the next edge.
- Between operations: TCK=0, TMS=0 (TAP held in Run-Test/Idle), TDI=0.

## Test plan
- **Post-reset IR-only.** DIV=2, Rst released, Start with Instr=6'h01, Dr_Len=0, Tap_Rst=0.
  - TLR runs anyway; T=18; Done at edge 73.
  - TMS per period: 1,1,1,1,1,0,1,1,0,0,0,0,0,0,0,1,1,0.
  - TDI during shift: 1,0,0,0,0,0.
- **IR+DR loopback.** TDO tied to TDI; second op with Instr=6'h12, Dr_Len=8, Dr_In=8'hA5.
  - T=25; Dr_Out=64'hA5.
  - TDI shift bits: 0,1,0,0,1,0 then 1,0,1,0,0,1,0,1.
- **Maximum length with TDO=1.** Dr_Len=64 → Dr_Out=all ones. Dr_Len=100 → clamped, T=12+69.
- **Busy protection.** Start pulsed mid-operation → ignored; exactly one Done; TCK count unchanged.
- **Reset mid-shift.** Assert Rst during SHIFT_DR → TCK=0, TMS=1, Busy=0, no Done. The next Start with Tap_Rst=0 still performs the 6-period TLR.
- **Back-to-back.** Start asserted in the Done cycle → accepted. Busy re-rises on the next edge, with no missed or extra TCK edges.

Source files
------------

// File: rtl/jtag_tap_driver_if.sv
// Request/response and JTAG pin bundle between a sequencer client, jtag_tap_driver and the TAP.
// The master side is the client/TAP model; the slave side is the driver itself.
interface jtag_tap_driver_if #(
  parameter int unsigned IR_WIDTH = 6,
  parameter int unsigned DR_MAX   = 64
);
  logic                start;
  logic                tap_rst;
  logic [IR_WIDTH-1:0] instr;
  logic [6:0]          dr_len;
  logic [DR_MAX-1:0]   dr_in;
  logic [DR_MAX-1:0]   dr_out;
  logic                busy;
  logic                done;
  logic                tck;
  logic                tms;
  logic                tdi;
  logic                tdo;

  modport master (
    output start, tap_rst, instr, dr_len, dr_in, tdo,
    input  dr_out, busy, done, tck, tms, tdi
  );

  modport slave (
    input  start, tap_rst, instr, dr_len, dr_in, tdo,
    output dr_out, busy, done, tck, tms, tdi
  );
endinterface

// File: rtl/jtag_tap_driver.sv
// JTAG master for the slow-control TAP: optional Test-Logic-Reset, IR write, optional DR shift,
// ending in Run-Test/Idle with captured TDO bits in dr_out.
module jtag_tap_driver #(
  parameter int unsigned IR_WIDTH = 6,
  parameter int unsigned DR_MAX   = 64,
  parameter int unsigned DIV      = 4
) (
  input  logic               clk,
  input  logic               rst,
  jtag_tap_driver_if.slave   bus
);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned LEN_W = 7;

  typedef enum logic [3:0] {
    IDLE, TLR, IR_HDR, SHIFT_IR, IR_TRL, DR_HDR, SHIFT_DR, DR_TRL, FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                pend_q, pend_d, go_q, go_d, tap_rst_q, tap_rst_d;
  logic [IR_WIDTH-1:0] instr_q, instr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DR_MAX-1:0]   dr_in_q, dr_in_d, dr_out_q, dr_out_d;
  state_e              first, nxt;
  logic [LEN_W-1:0]    nxt_cnt;
  logic                tick;

  // Index of the final TCK period spent in each state.
  function automatic logic [LEN_W-1:0] last_cnt(state_e s, logic [LEN_W-1:0] len);
    case (s)
      TLR:      return LEN_W'(5);
      IR_HDR:   return LEN_W'(3);
      SHIFT_IR: return LEN_W'(IR_WIDTH - 1);
      IR_TRL:   return LEN_W'(1);
      DR_HDR:   return LEN_W'(2);
      SHIFT_DR: return len - LEN_W'(1);
      DR_TRL:   return LEN_W'(1);
      default:  return '0;
    endcase
  endfunction

  function automatic state_e next_state(state_e s, logic [LEN_W-1:0] len);
    case (s)
      TLR:      return IR_HDR;
      IR_HDR:   return SHIFT_IR;
      SHIFT_IR: return IR_TRL;
      IR_TRL:   return (len == '0) ? FINISH : DR_HDR;
      DR_HDR:   return SHIFT_DR;
      SHIFT_DR: return DR_TRL;
      default:  return FINISH;
    endcase
  endfunction

  function automatic logic tms_of(state_e s, logic [LEN_W-1:0] cnt, logic [LEN_W-1:0] len);
    case (s)
      TLR:      return cnt != LEN_W'(5);
      IR_HDR:   return cnt < LEN_W'(2);
      SHIFT_IR: return cnt == LEN_W'(IR_WIDTH - 1);
      SHIFT_DR: return cnt == len - LEN_W'(1);
      IR_TRL, DR_HDR, DR_TRL: return cnt == '0;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic tdi_of(state_e s, logic [LEN_W-1:0] cnt,
                                  logic [IR_WIDTH-1:0] ir, logic [DR_MAX-1:0] dr);
    logic [IR_WIDTH-1:0] ir_sh;
    logic [DR_MAX-1:0]   dr_sh;
    ir_sh = ir >> cnt;
    dr_sh = dr >> cnt;
    case (s)
      SHIFT_IR: return ir_sh[0];
      SHIFT_DR: return dr_sh[0];
      default:  return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    tck_d     = tck_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pend_d    = pend_q;
    go_d      = 1'b0;
    tap_rst_d = tap_rst_q;
    instr_d   = instr_q;
    len_d     = len_q;
    dr_in_d   = dr_in_q;
    dr_out_d  = dr_out_q;
    first     = (pend_q || tap_rst_q) ? TLR : IR_HDR;
    nxt       = state_q;
    nxt_cnt   = cnt_q + LEN_W'(1);
    tick      = (div_q == DIV_W'(DIV - 1));

    if (state_q == IDLE || state_q == FINISH) begin
      state_d = IDLE;
      if (go_q) begin
        // First TCK low phase starts here; neither opening state shifts data.
        state_d = first;
        cnt_d   = '0;
        div_d   = '0;
        tck_d   = 1'b0;
        busy_d  = 1'b1;
        pend_d  = 1'b0;
        tms_d   = tms_of(first, '0, len_q);
        tdi_d   = 1'b0;
      end else if (bus.start) begin
        go_d      = 1'b1;
        tap_rst_d = bus.tap_rst;
        instr_d   = bus.instr;
        len_d     = (bus.dr_len > LEN_W'(DR_MAX)) ? LEN_W'(DR_MAX) : bus.dr_len;
        dr_in_d   = bus.dr_in;
        dr_out_d  = '0;
      end
    end else if (!tick) begin
      div_d = div_q + DIV_W'(1);
    end else begin
      div_d = '0;
      if (!tck_q) begin
        tck_d = 1'b1;
        if (state_q == SHIFT_DR && bus.tdo)
          dr_out_d = dr_out_q | (DR_MAX'(1) << cnt_q);
      end else begin
        if (cnt_q == last_cnt(state_q, len_q)) begin
          nxt     = next_state(state_q, len_q);
          nxt_cnt = '0;
        end
        tck_d   = 1'b0;
        state_d = nxt;
        cnt_d   = nxt_cnt;
        if (nxt == FINISH) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          tms_d  = 1'b0;
          tdi_d  = 1'b0;
        end else begin
          tms_d = tms_of(nxt, nxt_cnt, len_q);
          tdi_d = tdi_of(nxt, nxt_cnt, instr_q, dr_in_q);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      tck_q     <= 1'b0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pend_q    <= 1'b1;
      go_q      <= 1'b0;
      tap_rst_q <= 1'b0;
      instr_q   <= '0;
      len_q     <= '0;
      dr_in_q   <= '0;
      dr_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      tck_q     <= tck_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pend_q    <= pend_d;
      go_q      <= go_d;
      tap_rst_q <= tap_rst_d;
      instr_q   <= instr_d;
      len_q     <= len_d;
      dr_in_q   <= dr_in_d;
      dr_out_q  <= dr_out_d;
    end
  end

  assign bus.tck    = tck_q;
  assign bus.tms    = tms_q;
  assign bus.tdi    = tdi_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.dr_out = dr_out_q;
endmodule

// File: tb/tb_jtag_tap_driver.sv
// Directed bench for jtag_tap_driver at DIV=2: TCK-edge TMS/TDI log, edge-accurate Done timing,
// loopback capture, clamping, busy protection, mid-shift reset and back-to-back operations.
module tb_jtag_tap_driver;
  logic clk;
  logic rst;
  logic lb;
  logic tdo_val;
  int   total;
  int   bad;
  int   edge_n;
  int   rise_cnt;
  int   done_cnt;
  logic tck_prev;
  logic tms_log [4096];
  logic tdi_log [4096];

  jtag_tap_driver_if #(.IR_WIDTH(6), .DR_MAX(64)) bus ();

  jtag_tap_driver #(.IR_WIDTH(6), .DR_MAX(64), .DIV(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.tdo = lb ? bus.tdi : tdo_val;

  always #5 clk = ~clk;

  always @(posedge clk) edge_n++;

  // Record TMS/TDI as seen by the TAP at each TCK rising edge.
  always @(negedge clk) begin
    if (bus.tck && !tck_prev) begin
      tms_log[rise_cnt % 4096] = bus.tms;
      tdi_log[rise_cnt % 4096] = bus.tdi;
      rise_cnt++;
    end
    tck_prev = bus.tck;
    if (bus.done) done_cnt++;
  end

  task automatic run_op(input logic trst, input logic [5:0] ins, input logic [6:0] len,
                        input logic [63:0] din, output int rises, output int dedge,
                        output logic [63:0] dout, output int base);
    int e0;
    bit seen;
    @(negedge clk);
    bus.tap_rst = trst;
    bus.instr   = ins;
    bus.dr_len  = len;
    bus.dr_in   = din;
    bus.start   = 1'b1;
    base = rise_cnt;
    @(negedge clk);
    bus.start = 1'b0;
    e0 = edge_n;
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.done) begin seen = 1; break; end
    end
    dedge = seen ? edge_n - e0 : -1;
    @(negedge clk);
    rises = rise_cnt - base;
    dout  = bus.dr_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.tck !== 1'b0) begin bad++; $display("FAIL reset_tck got=%b exp=0", bus.tck); end
    total++; if (bus.tms !== 1'b1) begin bad++; $display("FAIL reset_tms got=%b exp=1", bus.tms); end
    total++; if (bus.tdi !== 1'b0) begin bad++; $display("FAIL reset_tdi got=%b exp=0", bus.tdi); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.dr_out !== 64'h0) begin bad++; $display("FAIL reset_dr_out got=%h exp=0", bus.dr_out); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_post_reset_ir();
    int r, d, b;
    logic [63:0] o;
    int exp_tms [18] = '{1,1,1,1,1,0,1,1,0,0,0,0,0,0,0,1,1,0};
    run_op(1'b0, 6'h01, 7'd0, 64'h0, r, d, o, b);
    total++; if (d != 73) begin bad++; $display("FAIL ir_only_done_edge got=%0d exp=73", d); end
    total++; if (r != 18) begin bad++; $display("FAIL ir_only_tck_periods got=%0d exp=18", r); end
    total++; if (o !== 64'h0) begin bad++; $display("FAIL ir_only_dr_out got=%h exp=0", o); end
    for (int i = 0; i < 18; i++) begin
      total++;
      if (tms_log[(b + i) % 4096] !== 1'(exp_tms[i])) begin
        bad++; $display("FAIL ir_only_tms[%0d] got=%b exp=%0d", i, tms_log[(b + i) % 4096], exp_tms[i]);
      end
      total++;
      if (tdi_log[(b + i) % 4096] !== 1'(i == 10)) begin
        bad++; $display("FAIL ir_only_tdi[%0d] got=%b exp=%b", i, tdi_log[(b + i) % 4096], i == 10);
      end
    end
    total++;
    if ({bus.tck, bus.tms, bus.tdi, bus.busy} !== 4'b0000) begin
      bad++; $display("FAIL idle_pins got=%b exp=0000", {bus.tck, bus.tms, bus.tdi, bus.busy});
    end
  endtask

  task automatic test_loopback();
    int r, d, b;
    logic [63:0] o;
    int exp_tms [25] = '{1,1,0,0, 0,0,0,0,0,1, 1,0, 1,0,0, 0,0,0,0,0,0,0,1, 1,0};
    int exp_tdi [25] = '{0,0,0,0, 0,1,0,0,1,0, 0,0, 0,0,0, 1,0,1,0,0,1,0,1, 0,0};
    lb = 1'b1;
    run_op(1'b0, 6'h12, 7'd8, 64'hA5, r, d, o, b);
    total++; if (d != 101) begin bad++; $display("FAIL loop_done_edge got=%0d exp=101", d); end
    total++; if (r != 25) begin bad++; $display("FAIL loop_tck_periods got=%0d exp=25", r); end
    total++; if (o !== 64'hA5) begin bad++; $display("FAIL loop_dr_out got=%h exp=a5", o); end
    for (int i = 0; i < 25; i++) begin
      total++;
      if (tms_log[(b + i) % 4096] !== 1'(exp_tms[i])) begin
        bad++; $display("FAIL loop_tms[%0d] got=%b exp=%0d", i, tms_log[(b + i) % 4096], exp_tms[i]);
      end
      total++;
      if (tdi_log[(b + i) % 4096] !== 1'(exp_tdi[i])) begin
        bad++; $display("FAIL loop_tdi[%0d] got=%b exp=%0d", i, tdi_log[(b + i) % 4096], exp_tdi[i]);
      end
    end
    lb = 1'b0;
  endtask

  task automatic test_max_len();
    int r, d, b;
    logic [63:0] o;
    tdo_val = 1'b1;
    run_op(1'b0, 6'h3F, 7'd64, 64'h0123_4567_89AB_CDEF, r, d, o, b);
    total++; if (o !== '1) begin bad++; $display("FAIL max64_dr_out got=%h exp=all ones", o); end
    total++; if (r != 81) begin bad++; $display("FAIL max64_tck_periods got=%0d exp=81", r); end
    total++; if (d != 325) begin bad++; $display("FAIL max64_done_edge got=%0d exp=325", d); end
    run_op(1'b0, 6'h3F, 7'd100, 64'h0, r, d, o, b);
    total++; if (o !== '1) begin bad++; $display("FAIL clamp_dr_out got=%h exp=all ones", o); end
    total++; if (r != 81) begin bad++; $display("FAIL clamp_tck_periods got=%0d exp=81", r); end
    total++; if (d != 325) begin bad++; $display("FAIL clamp_done_edge got=%0d exp=325", d); end
    run_op(1'b0, 6'h3F, 7'd8, 64'h0, r, d, o, b);
    total++; if (o !== 64'hFF) begin bad++; $display("FAIL len8_dr_out got=%h exp=ff", o); end
    total++; if (r != 25) begin bad++; $display("FAIL len8_tck_periods got=%0d exp=25", r); end
    tdo_val = 1'b0;
  endtask

  task automatic test_busy();
    int r, d, b, bd;
    logic [63:0] o;
    bd = done_cnt;
    fork
      run_op(1'b0, 6'h0A, 7'd4, 64'hF, r, d, o, b);
      begin
        repeat (30) @(negedge clk);
        bus.start = 1'b1;
        bus.instr = 6'h2A;
        @(negedge clk);
        bus.start = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    total++; if (r != 21) begin bad++; $display("FAIL busy_tck_periods got=%0d exp=21", r); end
    total++; if (d != 85) begin bad++; $display("FAIL busy_done_edge got=%0d exp=85", d); end
    total++; if (done_cnt - bd != 1) begin bad++; $display("FAIL busy_done_count got=%0d exp=1", done_cnt - bd); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_after got=%b exp=0", bus.busy); end
  endtask

  task automatic test_reset_mid_shift();
    int r, d, b, br, bd;
    bit reached;
    logic [63:0] o;
    tdo_val = 1'b1;
    br = rise_cnt;
    bd = done_cnt;
    @(negedge clk);
    bus.tap_rst = 1'b0; bus.instr = 6'h11; bus.dr_len = 7'd16; bus.dr_in = 64'hFFFF; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    reached = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rise_cnt - br >= 17) begin reached = 1; break; end
    end
    total++; if (!reached || bus.busy !== 1'b1) begin bad++; $display("FAIL mid_shift_reach got=%b busy=%b exp=1", reached, bus.busy); end
    rst = 1'b1;
    #1;
    total++;
    if ({bus.tck, bus.tms, bus.tdi, bus.busy, bus.done} !== 5'b01000) begin
      bad++; $display("FAIL mid_rst_pins got=%b exp=01000", {bus.tck, bus.tms, bus.tdi, bus.busy, bus.done});
    end
    total++; if (bus.dr_out !== 64'h0) begin bad++; $display("FAIL mid_rst_dr_out got=%h exp=0", bus.dr_out); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    br = rise_cnt;
    repeat (20) @(negedge clk);
    total++; if (done_cnt != bd) begin bad++; $display("FAIL mid_rst_no_done got=%0d exp=%0d", done_cnt, bd); end
    total++; if (rise_cnt != br) begin bad++; $display("FAIL mid_rst_no_tck got=%0d exp=%0d", rise_cnt, br); end
    tdo_val = 1'b0;
    run_op(1'b0, 6'h05, 7'd0, 64'h0, r, d, o, b);
    total++; if (r != 18) begin bad++; $display("FAIL post_rst_tck_periods got=%0d exp=18", r); end
    total++; if (d != 73) begin bad++; $display("FAIL post_rst_done_edge got=%0d exp=73", d); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (tms_log[(b + i) % 4096] !== 1'(i != 5)) begin
        bad++; $display("FAIL post_rst_tms[%0d] got=%b exp=%b", i, tms_log[(b + i) % 4096], i != 5);
      end
    end
  endtask

  task automatic test_back_to_back();
    int br, bd, e0, e1;
    bit seen;
    lb = 1'b1;
    br = rise_cnt;
    bd = done_cnt;
    @(negedge clk);
    bus.tap_rst = 1'b0; bus.instr = 6'h07; bus.dr_len = 7'd2; bus.dr_in = 64'h2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    e0 = edge_n;
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.done) begin seen = 1; break; end
    end
    total++; if (!seen || edge_n - e0 != 77) begin bad++; $display("FAIL b2b_a_done_edge got=%0d exp=77", seen ? edge_n - e0 : -1); end
    total++; if (bus.busy !== 1'b0 || bus.tck !== 1'b0) begin bad++; $display("FAIL b2b_a_end busy=%b tck=%b exp=0,0", bus.busy, bus.tck); end
    total++; if (bus.dr_out !== 64'h2) begin bad++; $display("FAIL b2b_a_dr_out got=%h exp=2", bus.dr_out); end
    bus.tap_rst = 1'b1; bus.instr = 6'h38; bus.dr_len = 7'd3; bus.dr_in = 64'h5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    e1 = edge_n;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_accept_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_rise got=%b exp=1", bus.busy); end
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.done) begin seen = 1; break; end
    end
    total++; if (!seen || edge_n - e1 != 105) begin bad++; $display("FAIL b2b_b_done_edge got=%0d exp=105", seen ? edge_n - e1 : -1); end
    @(negedge clk);
    total++; if (rise_cnt - br != 45) begin bad++; $display("FAIL b2b_tck_periods got=%0d exp=45", rise_cnt - br); end
    total++; if (done_cnt - bd != 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - bd); end
    total++; if (bus.dr_out !== 64'h5) begin bad++; $display("FAIL b2b_b_dr_out got=%h exp=5", bus.dr_out); end
    lb = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    lb = 1'b0;
    tdo_val = 1'b0;
    total = 0;
    bad = 0;
    edge_n = 0;
    rise_cnt = 0;
    done_cnt = 0;
    tck_prev = 1'b0;
    bus.start = 1'b0;
    bus.tap_rst = 1'b0;
    bus.instr = '0;
    bus.dr_len = '0;
    bus.dr_in = '0;
    test_reset();
    test_post_reset_ir();
    test_loopback();
    test_max_len();
    test_busy();
    test_reset_mid_shift();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
